spi_txn_arbiter: RTL and testbench

Round-robin transaction scheduler sharing one SPI master channel among NUM_REQ requesters. Accepts single-byte read/write requests (7-bit address, rd/wr bit, 8-bit data), sequences the master's `start` window, holds operands stable for the whole frame, and returns read data with a per-requester response pulse. Sits between on-chip clients and the master side of the SPI top level, in the `mclk` domain.

---
 rtl/spi_arb_pkg.sv | 13 +
 rtl/spi_rr_picker.sv | 29 ++
 rtl/spi_txn_arbiter.sv | 118 +++++++++++
 tb/tb_spi_txn_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI transaction arbiter.
package spi_arb_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, XFER, GAP} arb_state_t;

    typedef struct packed {
        logic              rd_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } spi_req_t;
endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: searches from ptr+1 upward, wrapping,
// and returns the first pending requester as a one-hot grant plus its index.
module spi_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);
    // Rotating priority scan; the pointer itself is checked last.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
        if (found) grant[winner] = 1'b1;
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI master among NUM_REQ requesters.
// One frame: IDLE accept -> XFER (start high) -> GAP (start low, response).
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = 18,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_rd_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      start,
    output logic                      master_rd_wr,
    output logic [ADDR_W-1:0]         master_address,
    output logic [DATA_W-1:0]         master_out_data,
    input  logic [DATA_W-1:0]         master_in_data,
    output logic                      busy
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    arb_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic               accept;
    spi_req_t           reqs [NUM_REQ];

    // Unpack the flat per-requester buses into request structs.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign reqs[i] = '{rd_wr: req_rd_wr[i],
                           addr:  req_addr[ADDR_W*i +: ADDR_W],
                           wdata: req_wdata[DATA_W*i +: DATA_W]};
    end

    spi_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req    (req_valid),
        .ptr    (last_grant),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    // Accept is gated by reset so nothing is taken while reset is sampled high.
    assign accept    = (state == IDLE) && found && !reset;
    assign req_ready = {NUM_REQ{accept}} & grant;
    assign busy      = (state != IDLE);

    // Frame sequencer; master_* change only on accept, rsp_rdata doubles as
    // the read buffer and holds between responses.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            start           <= 1'b0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            master_rd_wr    <= 1'b0;
            master_address  <= '0;
            master_out_data <= '0;
            owner           <= '0;
            last_grant      <= IDX_W'(NUM_REQ - 1);
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        master_rd_wr    <= reqs[winner].rd_wr;
                        master_address  <= reqs[winner].addr;
                        master_out_data <= reqs[winner].wdata;
                        owner           <= winner;
                        last_grant      <= winner;
                        start           <= 1'b1;
                        cnt             <= '0;
                        state           <= XFER;
                    end
                end
                XFER: begin
                    if (cnt == XFER_LAST) begin
                        rsp_rdata <= master_rd_wr ? master_in_data : '0;
                        rsp_valid <= NUM_REQ'(1) << owner;
                        start     <= 1'b0;
                        cnt       <= '0;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    start <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized bench for spi_txn_arbiter against a frame-offset reference model.
module tb_spi_txn_arbiter;
    localparam int N  = 4;
    localparam int XC = 18;
    localparam int GC = 2;

    logic           mclk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready, req_rd_wr, rsp_valid;
    logic [N*7-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [7:0]     rsp_rdata, master_out_data, master_in_data;
    logic [6:0]     master_address;
    logic           start, master_rd_wr, busy;

    spi_txn_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XC), .GAP_CYCLES(GC)) dut (
        .mclk            (mclk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd_wr       (req_rd_wr),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .start           (start),
        .master_rd_wr    (master_rd_wr),
        .master_address  (master_address),
        .master_out_data (master_out_data),
        .master_in_data  (master_in_data),
        .busy            (busy)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_t = -1 when idle, else cycles since the accept cycle.
    int         m_t;
    int         m_last;
    int         m_owner;
    logic       m_rd;
    logic [6:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] m_buf;
    logic [N-1:0] granted;
    bit         did_rst;

    task automatic model_reset();
        m_t = -1; m_last = N - 1; m_owner = 0;
        m_rd = 1'b0; m_addr = '0; m_wd = '0; m_buf = '0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int i);
        req_valid[i]       = 1'b1;
        req_rd_wr[i]       = 1'($urandom_range(0, 1));
        req_addr[7*i +: 7] = 7'($urandom);
        req_wdata[8*i +: 8] = 8'($urandom);
    endtask

    task automatic drive(input int cyc);
        reset = (cyc < 3);
        if (cyc >= 150 && !did_rst && m_t == 9) begin
            reset = 1'b1;
            did_rst = 1'b1;
        end
        if (cyc >= 300 && $urandom_range(0, 199) == 0) reset = 1'b1;
        master_in_data = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            if (granted[i]) req_valid[i] = 1'b0;
            if (cyc < 60) begin
                if (cyc == 0 && i == 0) begin
                    req_valid[0] = 1'b1; req_rd_wr[0] = 1'b0;
                    req_addr[6:0] = 7'h15; req_wdata[7:0] = 8'hA5;
                end
                if (cyc == 30 && i == 2) begin
                    req_valid[2] = 1'b1; req_rd_wr[2] = 1'b1;
                    req_addr[20:14] = 7'h3C; req_wdata[23:16] = 8'h00;
                end
            end else if (cyc < 300) begin
                if (!req_valid[i]) raise(i);
            end else begin
                if (req_valid[i] && $urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) raise(i);
            end
        end
    endtask

    task automatic check_and_step();
        int w;
        logic [N-1:0] e_ready, e_rsp;
        logic e_start, e_busy;
        w       = (m_t < 0 && !reset) ? rr_pick(req_valid) : -1;
        e_ready = (w >= 0) ? (N'(1) << w) : '0;
        e_start = (m_t >= 1 && m_t <= XC);
        e_busy  = (m_t >= 1);
        e_rsp   = (m_t == XC + 1) ? (N'(1) << m_owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("start", 32'(start), 32'(e_start));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_buf));
        chk("master_rd_wr", 32'(master_rd_wr), 32'(m_rd));
        chk("master_address", 32'(master_address), 32'(m_addr));
        chk("master_out_data", 32'(master_out_data), 32'(m_wd));
        granted = e_ready;
        if (reset) begin
            model_reset();
        end else if (m_t < 0) begin
            if (w >= 0) begin
                m_t     = 1;
                m_owner = w;
                m_last  = w;
                m_rd    = req_rd_wr[w];
                m_addr  = req_addr[7*w +: 7];
                m_wd    = req_wdata[8*w +: 8];
            end
        end else begin
            if (m_t == XC) m_buf = m_rd ? master_in_data : 8'h00;
            if (m_t == XC + GC) m_t = -1;
            else m_t++;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_rd_wr = '0; req_addr = '0; req_wdata = '0;
        master_in_data = '0;
        granted = '0;
        did_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive(cyc);
            @(negedge mclk);
            check_and_step();
            @(posedge mclk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
